// File: rtl/aemb2_divu.sv
// aemb2_divu: iterative radix-2 restoring IDIV/IDIVU unit for the AEMB2 EX stage.
// Define AEMB_DIV_EARLY_EN to skip the dividend's leading zeros and shorten CALC.
module aemb2_divu #(
    parameter int AEMB_DWB = 32,
    parameter int AEMB_HTX = 1
) (
    input  logic                gclk,
    input  logic                grst,
    input  logic                dena,
    input  logic                gpha,
    input  logic                div_stb,
    input  logic                div_sgn,
    input  logic                div_kil,
    input  logic [AEMB_DWB-1:0] opa_of,
    input  logic [AEMB_DWB-1:0] opb_of,
    output logic [AEMB_DWB-1:0] quo_mx,
    output logic [AEMB_DWB-1:0] rem_mx,
    output logic                div_bsy,
    output logic                div_don,
    output logic                div_dz,
    output logic                div_ovf,
    output logic                div_pha
);
    localparam int N = AEMB_DWB;
    localparam int CW = $clog2(N) + 1;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] dvs_q, acc_q, quo_q, rem_q, opa_abs, opb_abs, acc_d;
    logic [N:0] par_q;
    logic [N+1:0] trial;
    logic qs_q, rs_q, pha_q, bsy_q, don_q, dz_q, ovf_q, tag_q, is_dz, is_ovf;
    always_comb begin
        opa_abs = (div_sgn && opa_of[N-1]) ? -opa_of : opa_of;
        opb_abs = (div_sgn && opb_of[N-1]) ? -opb_of : opb_of;
        is_dz = opa_of == '0;
        is_ovf = div_sgn && opb_of == {1'b1, {(N-1){1'b0}}} && (&opa_of);
        trial = {par_q, acc_q[N-1]} - {2'b00, dvs_q};
    end
`ifdef AEMB_DIV_EARLY_EN
    logic [CW-1:0] lz;
    always_comb begin
        lz = CW'(N);
        for (int i = 0; i < N; i++)
            if (opb_abs[i]) lz = CW'(N - 1 - i);
        acc_d = opb_abs << lz;
        cnt_d = lz;
    end
`else
    assign acc_d = opb_abs;
    assign cnt_d = '0;
`endif
    always_ff @(posedge gclk) begin
        if (grst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            dvs_q <= '0;
            acc_q <= '0;
            par_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            {qs_q, rs_q, pha_q, bsy_q, don_q, dz_q, ovf_q, tag_q} <= '0;
        end else if (dena) begin
            case (state_q)
                IDLE: if (div_stb) begin
                    bsy_q <= 1'b1;
                    dz_q <= is_dz;
                    ovf_q <= is_ovf;
                    if (is_dz || is_ovf) begin
                        state_q <= DONE;
                        don_q <= 1'b1;
                        quo_q <= is_dz ? '0 : {1'b1, {(N-1){1'b0}}};
                        rem_q <= '0;
                        tag_q <= gpha;
                    end else begin
                        // a zero dividend under early exit has no iterations left
                        state_q <= (cnt_d == CW'(N)) ? FIX : CALC;
                        cnt_q <= cnt_d;
                        dvs_q <= opa_abs;
                        acc_q <= acc_d;
                        par_q <= '0;
                        qs_q <= (opa_of[N-1] ^ opb_of[N-1]) & div_sgn;
                        rs_q <= opb_of[N-1] & div_sgn;
                        pha_q <= gpha;
                    end
                end
                CALC: if (div_kil) begin
                    state_q <= IDLE;
                    bsy_q <= 1'b0;
                end else begin
                    par_q <= trial[N+1] ? {par_q[N-1:0], acc_q[N-1]} : trial[N:0];
                    acc_q <= {acc_q[N-2:0], ~trial[N+1]};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) state_q <= FIX;
                end
                FIX: if (div_kil) begin
                    state_q <= IDLE;
                    bsy_q <= 1'b0;
                end else begin
                    quo_q <= qs_q ? -acc_q : acc_q;
                    rem_q <= rs_q ? -par_q[N-1:0] : par_q[N-1:0];
                    tag_q <= pha_q;
                    don_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    don_q <= 1'b0;
                    bsy_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign quo_mx = quo_q;
    assign rem_mx = rem_q;
    assign div_bsy = bsy_q;
    assign div_don = don_q;
    assign div_dz = dz_q;
    assign div_ovf = ovf_q;
    assign div_pha = (AEMB_HTX != 0) ? tag_q : 1'b0;
endmodule

// File: doc/aemb2_divu.md
Name: aemb2_divu

Overview:
- Parametrised iterative integer divide unit for the AEMB2 core.
- Sits beside the one-cycle integer unit in the EX stage. Accepts IDIV/IDIVU operands from the OF stage and returns the quotient, remainder and flags after a fixed multi-cycle latency.
- Generalised over the one-cycle unit: datapath width is a parameter, signed and unsigned modes are supported, and it provides a busy/done handshake, stall, kill, and hardware-thread tagging.

Parameters:
- AEMB_DWB, 32, datapath width N in bits (8..64).
- AEMB_HTX, 1, hardware threading present. When 0, the thread tag output is forced to 0.

Ports:
- gclk  in  1  system clock; all state changes on the rising edge.
- grst  in  1  synchronous active-high reset.
- dena  in  1  pipeline enable. When 0, all state and outputs hold.
- gpha  in  1  current thread phase; captured at start.
- div_stb  in  1  start request (IDIV/IDIVU decoded).
- div_sgn  in  1  1 = signed (IDIV), 0 = unsigned (IDIVU).
- div_kil  in  1  abort the operation in flight.
- opa_of  in  N  divisor (rA).
- opb_of  in  N  dividend (rB).
- quo_mx  out  N  quotient.
- rem_mx  out  N  remainder.
- div_bsy  out  1  high from the accepting edge until done.
- div_don  out  1  one-cycle completion pulse.
- div_dz  out  1  divide-by-zero flag.
- div_ovf  out  1  signed overflow flag.
- div_pha  out  1  thread tag of the result.

Behaviour:
- Reset: clock gclk, reset grst, synchronous active-high. On reset the state is IDLE and quo_mx, rem_mx, div_bsy, div_don, div_dz, div_ovf and div_pha are all 0.
- Edge qualification: every edge below is qualified by dena. With dena=0 the counter, state and outputs freeze, and div_don stays at its current value.
- States:
  - IDLE -> CALC when div_stb=1.
    - Captures |opa_of| and |opb_of| (magnitudes when div_sgn=1, raw values otherwise), the quotient sign (opa[N-1]^opb[N-1])&sgn, the remainder sign opb[N-1]&sgn, and gpha.
    - Sets div_bsy=1 and clears div_dz/div_ovf.
  - IDLE -> DONE directly, skipping CALC, in two cases:
    - Divide by zero (opa_of==0): quo=0, rem=0, div_dz=1.
    - Signed overflow (sgn, opb=-2^(N-1), opa=-1): quo=0x8..0, rem=0, div_ovf=1.
  - CALC: N iterations of radix-2 restoring division, one per edge, using a log2(N)+1 bit counter.
    - Partial remainder is N+1 bits wide.
    - Each iteration shifts in the next dividend bit, trial-subtracts the divisor, and keeps the result if it is non-negative.
    - After the N-th iteration the state moves to FIX.
  - FIX: conditionally negates the quotient and remainder (two's complement, N bits) according to the captured signs, then -> DONE.
  - DONE: div_don=1 for exactly one enabled cycle and div_bsy drops, then -> IDLE. A div_stb in the DONE cycle is ignored.
- Latency: with no stalls, div_don is high in the cycle N+2 enabled edges after the accepting edge, or 1 edge after it for the dz/ovf paths.
- Result hold: quo_mx, rem_mx, div_dz, div_ovf and div_pha are registered. They are valid from the div_don cycle and held until the next accepted start.
- div_stb while busy is ignored; no queueing.
- div_kil=1 in CALC or FIX -> IDLE on the next enabled edge. No div_don is issued, div_bsy goes to 0, and the outputs keep their prior values. div_kil in IDLE has no effect. If div_kil and div_stb are both high in IDLE, div_stb wins.
- grst mid-operation aborts immediately to reset values.
- Sign rules: the remainder takes the sign of the dividend; the quotient truncates toward zero.

Optional Feature:
- Macro: AEMB_DIV_EARLY_EN.
- When defined: at the accepting edge the unit computes lz = count of leading zeros of |dividend|. It pre-shifts the dividend and starts the counter at lz, so CALC runs N-lz iterations. Latency becomes N-lz+2, which is 2 when the dividend is 0. Results are identical to the non-early path.
- When not defined: fixed N+2 latency; no leading-zero logic is synthesised.

Test Plan (AEMB_DWB=32, dena=1 unless stated):
- Unsigned: opb=100, opa=7, sgn=0 -> div_don 34 cycles after start; quo=14, rem=2, dz=ovf=0, div_bsy high for 34 cycles.
- Signed: opb=-100 (0xFFFFFF9C), opa=7, sgn=1 -> quo=0xFFFFFFF2, rem=0xFFFFFFFE. Also opb=0xFFFFFFFF, sgn=0, opa=2 -> quo=0x7FFFFFFF, rem=1.
- Exceptions:
  - opa=0, opb=5 -> div_don 1 cycle after start; quo=0, div_dz=1.
  - opb=0x80000000, opa=0xFFFFFFFF, sgn=1 -> quo=0x80000000, div_ovf=1, 1-cycle latency.
- Stall: toggle dena low for 5 cycles mid-CALC -> div_don arrives 39 cycles after start, result unchanged. A div_stb issued during busy is ignored.
- Kill/reset: div_kil at iteration 10 -> div_bsy=0 next edge, no div_don, and the next start completes normally. grst at iteration 20 -> all outputs 0.
- Tag / early exit: gpha=1 at start -> div_pha=1 at done. With AEMB_DIV_EARLY_EN and opb=3, opa=1 -> latency 4, quo=3.
